// File: rtl/index_sequencer.sv
// Index sequencer: issues one seed load to the downstream register bank, then walks
// a ROWS x COLS index space over a valid/ready handshake and pulses done at the end.
module index_sequencer #(
    parameter int SIZE     = 3,
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int RW       = 2,
    parameter int CW       = 2,
    parameter int INIT_VAL = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            ready,
    output logic [RW-1:0]   row,
    output logic [CW-1:0]   col,
    output logic            valid,
    output logic            init_en,
    output logic [SIZE-1:0] init_val,
    output logic            busy,
    output logic            done
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    localparam logic [RW-1:0]   ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0]   COL_LAST = CW'(COLS - 1);
    localparam logic [SIZE-1:0] SEED     = SIZE'(INIT_VAL);

    state_t state;
    logic   beat;

    assign beat = valid & ready;

    // Every output is a register updated alongside the state, so start/ready never
    // reach an output combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            row      <= '0;
            col      <= '0;
            valid    <= 1'b0;
            init_en  <= 1'b0;
            init_val <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LOAD;
                        init_en  <= 1'b1;
                        init_val <= SEED;
                        busy     <= 1'b1;
                    end
                end
                LOAD: begin
                    state    <= RUN;
                    init_en  <= 1'b0;
                    init_val <= '0;
                    valid    <= 1'b1;
                end
                RUN: begin
                    if (beat) begin
                        if (col == COL_LAST) begin
                            col <= '0;
                            if (row == ROW_LAST) begin
                                state <= DONE;
                                row   <= '0;
                                valid <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                row <= row + RW'(1);
                            end
                        end else begin
                            col <= col + CW'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_index_sequencer.sv
// Bench for index_sequencer: a 4x4 and a 1x1 (seed 5) instance share one stimulus
// stream; each has its own pass-level reference model feeding a scoreboard.
module tb_index_sequencer;
    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic start = 1'b0;
    logic ready = 1'b0;
    int   nvec_m = 0;
    int   nerr_m = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : chk
        localparam int R  = (gi == 0) ? 4 : 1;
        localparam int C  = (gi == 0) ? 4 : 1;
        localparam int IV = (gi == 0) ? 0 : 5;

        logic [1:0] row;
        logic [1:0] col;
        logic [2:0] init_val;
        logic       valid, init_en, busy, done;

        int nv = 0;
        int ne = 0;
        int pend = 0;
        int cyc = 0;
        int in_pass = 0;
        int load_cyc = 0;
        int beats_left = 0;
        int init_q[$];
        int done_q[$];
        int row_q[$];
        int col_q[$];
        int rd_init = 0;
        int rd_done = 0;
        int rd_beat = 0;
        logic       stall_p = 1'b0;
        logic [1:0] row_p = 2'd0;
        logic [1:0] col_p = 2'd0;

        index_sequencer #(
            .SIZE(3), .ROWS(R), .COLS(C), .RW(2), .CW(2), .INIT_VAL(IV)
        ) dut (
            .clk(clk), .rst(rst), .start(start), .ready(ready),
            .row(row), .col(col), .valid(valid), .init_en(init_en),
            .init_val(init_val), .busy(busy), .done(done)
        );

        task automatic eq(input string nm, input int act, input int exp);
            nv++;
            if (act != exp) begin
                ne++;
                $display("FAIL dut%0d %s: got %0d, expected %0d (cycle %0d)", gi, nm, act, exp, cyc);
            end
        endtask

        // Reference model: a pass is accepted from idle, spends one seed cycle, then
        // consumes R*C ready-qualified edges, then one completion cycle.
        always @(posedge clk or posedge rst) begin
            if (rst) begin
                in_pass    = 0;
                beats_left = 0;
                init_q.delete();
                done_q.delete();
                row_q.delete();
                col_q.delete();
            end else begin
                cyc++;
                if (in_pass == 0) begin
                    if (start) begin
                        in_pass    = 1;
                        load_cyc   = cyc;
                        beats_left = R * C;
                        init_q.push_back(cyc);
                        for (int k = 0; k < R * C; k++) begin
                            row_q.push_back(k / C);
                            col_q.push_back(k % C);
                        end
                    end
                end else if (beats_left == 0) begin
                    in_pass = 0;
                end else if (cyc >= load_cyc + 2 && ready) begin
                    beats_left--;
                    if (beats_left == 0) done_q.push_back(cyc);
                end
            end
        end

        always @(negedge clk) begin
            if (rst) begin
                rd_init = 0;
                rd_done = 0;
                rd_beat = 0;
                stall_p = 1'b0;
            end else begin
                int exp_init;
                exp_init = int'(in_pass != 0 && cyc == load_cyc);
                eq("busy", int'(busy), int'(in_pass != 0));
                eq("init_en", int'(init_en), exp_init);
                eq("init_val", int'(init_val), (exp_init != 0) ? IV : 0);
                eq("valid", int'(valid), int'(in_pass != 0 && cyc > load_cyc && beats_left > 0));
                eq("done", int'(done), int'(in_pass != 0 && beats_left == 0));
                if (init_en) begin
                    if (rd_init >= init_q.size()) eq("init_unexpected", 1, 0);
                    else begin
                        eq("init_cycle", cyc, init_q[rd_init]);
                        rd_init++;
                    end
                end
                if (done) begin
                    if (rd_done >= done_q.size()) eq("done_unexpected", 1, 0);
                    else begin
                        eq("done_cycle", cyc, done_q[rd_done]);
                        rd_done++;
                    end
                end
                if (valid && ready) begin
                    if (rd_beat >= row_q.size()) eq("beat_unexpected", 1, 0);
                    else begin
                        eq("beat_row", int'(row), row_q[rd_beat]);
                        eq("beat_col", int'(col), col_q[rd_beat]);
                        rd_beat++;
                    end
                end
                if (!valid) eq("idx_zero", int'({row, col}), 0);
                if (stall_p && valid) begin
                    eq("row_hold", int'(row), int'(row_p));
                    eq("col_hold", int'(col), int'(col_p));
                end
                stall_p = valid && !ready;
                row_p   = row;
                col_p   = col;
            end
            pend = (init_q.size() - rd_init) + (done_q.size() - rd_done) + (row_q.size() - rd_beat);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input int act, input int exp);
        nvec_m++;
        if (act != exp) begin
            nerr_m++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_reset(input string nm);
        check({nm, "_dut0"}, int'({chk[0].row, chk[0].col, chk[0].valid, chk[0].init_en,
                                   chk[0].init_val, chk[0].busy, chk[0].done}), 0);
        check({nm, "_dut1"}, int'({chk[1].row, chk[1].col, chk[1].valid, chk[1].init_en,
                                   chk[1].init_val, chk[1].busy, chk[1].done}), 0);
    endtask

    task automatic wait_idx(input int r, input int c, input string nm);
        int n = 0;
        while (!(chk[0].valid && int'(chk[0].row) == r && int'(chk[0].col) == c) && n < 100) begin
            tick();
            n++;
        end
        check({nm, "_reached"}, int'(n < 100), 1);
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (!chk[0].done && n < 100) begin
            tick();
            n++;
        end
        check({nm, "_reached"}, int'(n < 100), 1);
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (chk[0].busy && n < 100) begin
            tick();
            n++;
        end
        check({nm, "_reached"}, int'(n < 100), 1);
    endtask

    initial begin
        int dones;
        int n;
        tick();
        tick();
        check_reset("reset_hold");
        rst = 1'b0;
        repeat (3) tick();
        check_reset("idle_no_start");

        // Nominal pass with the consumer always ready.
        ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle("nominal");
        tick();

        // Backpressure at (1,3).
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idx(1, 3, "bp");
        ready = 1'b0;
        repeat (3) tick();
        check("bp_row", int'(chk[0].row), 1);
        check("bp_col", int'(chk[0].col), 3);
        check("bp_valid", int'(chk[0].valid), 1);
        ready = 1'b1;
        tick();
        check("bp_next", int'({chk[0].row, chk[0].col}), 8);
        wait_idle("bp");
        tick();

        // Start pulses during LOAD, mid-RUN and DONE must be ignored.
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        wait_idx(2, 2, "ign");
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("ign");
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("ign_idle", int'(chk[0].busy), 0);

        // Start held high: two back-to-back passes.
        start = 1'b1;
        dones = 0;
        n = 0;
        while (dones < 2 && n < 200) begin
            tick();
            n++;
            if (chk[0].done) dones++;
        end
        check("cont_two_passes", dones, 2);
        start = 1'b0;
        wait_idle("cont");

        // Randomized start/ready traffic.
        repeat (400) begin
            start = ($urandom % 8) == 0;
            ready = ($urandom % 4) != 0;
            tick();
        end
        start = 1'b0;
        ready = 1'b1;
        repeat (30) tick();

        // Asynchronous reset in the middle of a pass.
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idx(2, 1, "midrst");
        #2;
        rst = 1'b1;
        #1;
        check_reset("reset_async");
        tick();
        rst = 1'b0;
        repeat (5) tick();
        check_reset("post_reset_idle");

        repeat (3) tick();
        check("pending_dut0", chk[0].pend, 0);
        check("pending_dut1", chk[1].pend, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec_m + chk[0].nv + chk[1].nv, nerr_m + chk[0].ne + chk[1].ne);
        $finish;
    end
endmodule
